// File: rtl/monostable_multi.sv
// monostable_multi: multi-channel retriggerable pulse stretcher.
// Each channel synchronises its raw input, detects rising edges, and emits
// a pulse of programmable length (in clk cycles). An optional hold-off window
// follows each pulse. overlap flags cycles in which two or more channels
// drove out high in the previous cycle. This is the shoot-through condition
// between complementary gate-drive signals.
//
// Optional feature: define MONOSTABLE_TRIG_COUNT_EN to add the trig_count
// output. It holds one saturating counter of accepted triggers per channel.
module monostable_multi #(
  parameter int CHANNELS    = 2,
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RETRIGGER   = 1,
  parameter int HOLDOFF     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      in,
  input  logic [SIZE-1:0]          timeout,
  input  logic                     clr,
  output logic [CHANNELS-1:0]      out,
  output logic                     busy,
  output logic                     overlap,
  output logic                     overlap_sticky
`ifdef MONOSTABLE_TRIG_COUNT_EN
  ,
  output logic [CHANNELS*SIZE-1:0] trig_count
`endif
);

  localparam logic [SIZE-1:0] CNT_ONE     = SIZE'(1);
  localparam logic [SIZE-1:0] HOLD_LOAD   = SIZE'(HOLDOFF);
  localparam bit              HAS_HOLDOFF = (HOLDOFF > 0);
  localparam bit              CAN_RETRIG  = (RETRIGGER != 0);

  // ACTIVE is the only encoding with bit 0 set, so out is a direct flop output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_e;

  function automatic int unsigned popcount(input logic [CHANNELS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Synchroniser and edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  prev_q;
  logic [CHANNELS-1:0]                  synced;
  logic [CHANNELS-1:0]                  trig_d, trig_q;

  // Shift the raw inputs into the synchroniser and form the edge pulse.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    synced = sync_q[SYNC_STAGES-1];
    trig_d = synced & ~prev_q;
  end

  // Synchroniser, previous-value and registered-trigger flops.
  // trig is registered so that the FSM sees a clean flop-driven trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      trig_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= synced;
      trig_q <= trig_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel pulse FSM
  // ---------------------------------------------------------------------
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [SIZE-1:0]     cnt_q   [CHANNELS];
  logic [SIZE-1:0]     cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] load_ok;

  // A trigger can only start or extend a pulse when the length is non-zero.
  assign load_ok = trig_q & {CHANNELS{timeout != '0}};

  // Next-state and counter logic for every channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (load_ok[i]) begin
            state_d[i] = ST_ACTIVE;
            cnt_d[i]   = timeout;
          end
        end
        ST_ACTIVE: begin
          if (CAN_RETRIG && load_ok[i]) begin
            cnt_d[i] = timeout;
          end else if (cnt_q[i] == CNT_ONE) begin
            if (HAS_HOLDOFF) begin
              state_d[i] = ST_HOLDOFF;
              cnt_d[i]   = HOLD_LOAD;
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        ST_HOLDOFF: begin
          // Triggers are dropped here, not queued.
          if (cnt_q[i] == CNT_ONE) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State and counter registers; reset aborts any pulse at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Decode out and busy from the registered state only.
  always_comb begin
    out  = '0;
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      out[i] = state_q[i][0];
      busy   = busy | (state_q[i] != ST_IDLE);
    end
  end

  // ---------------------------------------------------------------------
  // Overlap detection
  // ---------------------------------------------------------------------
  generate
    if (CHANNELS >= 2) begin : g_overlap
      logic overlap_q, overlap_d;
      logic sticky_q, sticky_d;

      // A set on the same cycle as clr wins over the clear.
      always_comb begin
        overlap_d = (popcount(out) >= 32'd2);
        sticky_d  = (sticky_q & ~clr) | overlap_q;
      end

      // Overlap and sticky flag registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          overlap_q <= 1'b0;
          sticky_q  <= 1'b0;
        end else begin
          overlap_q <= overlap_d;
          sticky_q  <= sticky_d;
        end
      end

      assign overlap        = overlap_q;
      assign overlap_sticky = sticky_q;
    end else begin : g_no_overlap
      assign overlap        = 1'b0;
      assign overlap_sticky = 1'b0;
    end
  endgenerate

`ifdef MONOSTABLE_TRIG_COUNT_EN
  // ---------------------------------------------------------------------
  // Accepted-trigger counters
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0] accept;
  logic [SIZE-1:0]     tcnt_q [CHANNELS];

  function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // A trigger counts only when the FSM actually loads the counter from it.
  always_comb begin
    accept = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept[i] = load_ok[i] &&
                  ((state_q[i] == ST_IDLE) ||
                   (CAN_RETRIG && (state_q[i] == ST_ACTIVE)));
    end
  end

  // Saturating counters; clr takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tcnt_q[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept[i]) begin
          tcnt_q[i] <= sat_inc(tcnt_q[i]);
        end
      end
    end
  end

  // Pack the per-channel counters onto the flat output port.
  always_comb begin
    trig_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      trig_count[i*SIZE +: SIZE] = tcnt_q[i];
    end
  end
`endif

endmodule

// File: doc/monostable_multi.md
Name: monostable_multi

Overview:
- Multi-channel retriggerable pulse stretcher; parametrised successor of the single-channel monostable used on the shoot-through detector gate-drive inputs.
- Per channel:
  - synchronises the raw input;
  - detects rising edges;
  - emits a pulse whose programmable length is in clk cycles;
  - optionally enforces a hold-off window after each pulse.
- Flags any cycle in which two or more channels are active. This is the shoot-through condition between complementary gate signals.

Parameters:
- CHANNELS, 2, number of independent channels (>=1).
- SIZE, 8, counter width; max pulse length 2^SIZE-1 cycles.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- RETRIGGER, 1, 1 = a trigger while active reloads the counter; 0 = a trigger while active is ignored.
- HOLDOFF, 0, hold-off length in cycles after each pulse (0 = none). Must fit in SIZE bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- in  input  CHANNELS  raw asynchronous trigger inputs, one bit per channel.
- timeout  input  SIZE  pulse length in cycles; sampled per channel at trigger acceptance.
- clr  input  1  synchronous clear of overlap_sticky.
- out  output  CHANNELS  stretched pulses, registered.
- busy  output  1  OR of all channels in ACTIVE or HOLDOFF.
- overlap  output  1  registered; high when >=2 bits of out were high in the previous cycle.
- overlap_sticky  output  1  latched overlap.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst is asynchronous, active-high. While asserted, every flop clears: synchronisers, edge registers, states = IDLE, counters = 0, out = 0, busy = 0, overlap = 0, overlap_sticky = 0.
  - Reset mid-pulse aborts the pulse immediately (out drops asynchronously).
- Synchroniser and edge detect:
  - in[i] passes through SYNC_STAGES flops, then a previous-value flop.
  - trig[i] = synced & ~prev. Level-high inputs produce one trigger only.
- Per-channel FSM, states IDLE / ACTIVE / HOLDOFF, counter cnt[SIZE-1:0]:
  - IDLE:
    - trig and timeout != 0 -> ACTIVE, cnt <= timeout.
    - trig with timeout == 0 is ignored and the channel stays IDLE.
  - ACTIVE:
    - out[i] = 1.
    - RETRIGGER=1 and trig and timeout != 0 -> cnt <= timeout; the pulse extends.
    - Else if cnt == 1 -> HOLDOFF with cnt <= HOLDOFF when HOLDOFF>0, otherwise IDLE.
    - Else cnt <= cnt - 1.
    - Un-retriggered pulse width is exactly timeout cycles.
  - HOLDOFF:
    - out[i] = 0; all triggers are ignored.
    - cnt == 1 -> IDLE, else decrement.
    - A trigger edge arriving during HOLDOFF is lost. It is not queued.
- Latency: out[i] is high starting at clock edge SYNC_STAGES+2 counted from the first edge that samples in[i] high. That is edge 4 for default parameters.
- A timeout change during ACTIVE has no effect until the next accepted trigger or retrigger.
- out is decoded from registered state only; no combinational path from in to out.
- No arithmetic wrap: the counter only loads timeout (>=1) and decrements down to 1.
- Overlap:
  - overlap <= (popcount(out) >= 2).
  - overlap_sticky <= overlap_sticky & ~clr | overlap. If set and clr coincide, set wins.
- busy is combinational OR of the per-channel (state != IDLE).
- CHANNELS=1: overlap and overlap_sticky are tied to 0.

Optional Feature:
- Macro: MONOSTABLE_TRIG_COUNT_EN.
- Defined:
  - Adds output port trig_count, width CHANNELS*SIZE.
  - Channel i occupies bits [i*SIZE +: SIZE].
  - Each field is a saturating counter of accepted triggers, including retriggers. Ignored triggers are not counted: HOLDOFF, timeout == 0, and RETRIGGER=0 while active.
  - Saturates at 2^SIZE-1. Cleared by rst and by clr.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults, timeout=5, one 1-cycle high on in[0] (in[0] low otherwise) -> out[0] rises at edge 4, stays high exactly 5 cycles. out[1]=0, overlap=0, busy follows out[0].
- RETRIGGER=1, timeout=6, second in[0] edge 3 cycles after the first accepted -> out[0] high 3+6=9 cycles. Same stimulus with RETRIGGER=0 -> high 6 cycles.
- HOLDOFF=4, timeout=3, in[0] edges 4 cycles apart -> first pulse 3 cycles; second edge falls in HOLDOFF and produces no pulse. An edge 8 cycles after the first produces a pulse.
- in[0] and in[1] edges 2 cycles apart, timeout=5 -> overlap high for 3 cycles, starting one cycle after both outs are high. overlap_sticky stays 1 until clr; clr asserted alongside a live overlap leaves sticky at 1.
- rst asserted asynchronously mid-pulse (timeout=10, 4 cycles in) -> out, busy and sticky go 0 immediately; after release, a new edge gives a full 10-cycle pulse.
- timeout=0 with an in[0] edge -> no pulse, busy stays 0. With MONOSTABLE_TRIG_COUNT_EN and SIZE=3, 9 accepted triggers -> trig_count field for channel 0 = 7.
